// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, FSM states and counter width for mem_responder
package mem_pkg;
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
endpackage

// File: rtl/mem_lane_merge.sv
// mem_lane_merge: little-endian lane insert for stores and zero-extended lane extract for loads
module mem_lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] merged_o,
    output logic [31:0] rlane_o
);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] lane;
    // Shift the store lane into place under a byte/half/word mask; shift the load lane down
    always_comb begin
        sh       = {off_i, 3'b000};
        mask     = size_i == SIZE_BYTE ? 32'h0000_00FF << sh :
                   size_i == SIZE_HALF ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
        merged_o = (old_i & ~mask) | ((wdata_i << sh) & mask);
        lane     = old_i >> sh;
        rlane_o  = size_i == SIZE_BYTE ? {24'b0, lane[7:0]} :
                   size_i == SIZE_HALF ? {16'b0, lane[15:0]} : old_i;
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency single-outstanding memory responder; MEM_SUBWORD_STORE_EN enables half/byte stores
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [AW+1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH_WORDS];
    logic              mem_we;
    logic              req_err;
    logic              sub_err;
    logic              sub_wr;
    logic [AW-1:0]     idx;
    logic [31:0]       old_word;
    logic [31:0]       merged;
    logic [31:0]       rlane;

`ifdef MEM_SUBWORD_STORE_EN
    assign sub_err = 1'b0;
    assign sub_wr  = we_q && size_q != SIZE_WORD;
`else
    assign sub_err = req_we && req_size != SIZE_WORD;
    assign sub_wr  = 1'b0;
`endif

    assign req_err = req_size == SIZE_ILL
                  || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                  || (req_size == SIZE_HALF && req_addr[0])
                  || req_addr >= 32'(4 * DEPTH_WORDS)
                  || sub_err;

    assign idx       = addr_q[AW+1:2];
    assign old_word  = mem_q[idx];
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    mem_lane_merge u_merge (
        .old_i    (old_word),
        .wdata_i  (wdata_q),
        .size_i   (size_q),
        .off_i    (addr_q[1:0]),
        .merged_o (merged),
        .rlane_o  (rlane)
    );

    // Next-state logic: accept in IDLE, count latency in ACCESS, read-modify-write in MERGE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                size_d  = req_size;
                addr_d  = req_addr[AW+1:0];
                wdata_d = req_wdata;
                err_d   = req_err;
                rdata_d = '0;
                cnt_d   = CNT_W'(1);
                state_d = req_err ? RESP : ACCESS;
            end
            ACCESS: if (cnt_q == CNT_W'(LATENCY)) begin
                state_d = sub_wr ? MERGE : RESP;
                mem_we  = we_q && !sub_wr;
                rdata_d = we_q ? '0 : rlane;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef MEM_SUBWORD_STORE_EN
            MERGE: begin
                mem_we  = 1'b1;
                state_d = RESP;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Control and request-latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SIZE_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array; reset on the commit edge suppresses the write, contents are never cleared
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[idx] <= merged;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (LATENCY=2 main instance, LATENCY=1 timing instance)
module tb_mem_responder;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid1 = 1'b0, req_we1 = 1'b0;
    logic [31:0] req_addr1 = '0, req_wdata1 = '0;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int   cyc = 0;
    int   acc_cnt = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

`ifdef MEM_SUBWORD_STORE_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_we(req_we1), .req_size(2'b00), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready && !reset) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every response pulse
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.d);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
                chk("rsp_cycle", cyc, e.c);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee, input int dly);
        wait_ready();
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        sb.push_back('{d: ed, e: ee, c: cyc + dly});
        req_valid = 1'b0;
        wait_ready();
    endtask

    task automatic issue1(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ed);
        int a0;
        int n = 0;
        @(negedge clk);
        req_valid1 = 1'b1;
        req_we1    = we;
        req_addr1  = a;
        req_wdata1 = wd;
        @(posedge clk);
        #1;
        a0 = cyc;
        req_valid1 = 1'b0;
        @(negedge clk);
        while (!rsp_valid1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat1_cycle", cyc - a0, 32'd1);
        chk("lat1_rdata", rsp_rdata1, ed);
        chk("lat1_err", {31'b0, rsp_err1}, 32'd0);
    endtask

    initial begin
        int a0;
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_err", {31'b0, rsp_err}, 32'd0);

        // Word round trip
        issue(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, LAT);
        issue(1'b0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, LAT);

        // Sub-word reads and byte store
        issue(1'b1, 2'b00, 32'h20, 32'h11223344, 32'h0, 1'b0, LAT);
        issue(1'b0, 2'b10, 32'h21, 32'h0, 32'h00000033, 1'b0, LAT);
        issue(1'b0, 2'b01, 32'h20, 32'h0, 32'h00003344, 1'b0, LAT);
        issue(1'b1, 2'b10, 32'h22, 32'hFFFFFFAA, 32'h0, !SUB, SUB ? LAT + 1 : 0);
        issue(1'b0, 2'b00, 32'h20, 32'h0, SUB ? 32'h11AA3344 : 32'h11223344, 1'b0, LAT);
        issue(1'b0, 2'b01, 32'h22, 32'h0, SUB ? 32'h000011AA : 32'h00001122, 1'b0, LAT);
        issue(1'b1, 2'b01, 32'h20, 32'h0000BEEF, 32'h0, !SUB, SUB ? LAT + 1 : 0);
        issue(1'b0, 2'b00, 32'h20, 32'h0, SUB ? 32'h11AABEEF : 32'h11223344, 1'b0, LAT);

        // Errors and boundaries
        issue(1'b0, 2'b00, 32'h21, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b0, 2'b01, 32'h23, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b0, 2'b00, 32'h100, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b1, 2'b00, 32'h12, 32'hCAFEF00D, 32'h0, 1'b1, 0);
        issue(1'b1, 2'b00, 32'h110, 32'hCAFEF00D, 32'h0, 1'b1, 0);
        issue(1'b0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, LAT);
        issue(1'b1, 2'b00, 32'hFC, 32'hA5A5_5A5A, 32'h0, 1'b0, LAT);
        issue(1'b0, 2'b00, 32'hFC, 32'h0, 32'hA5A5_5A5A, 1'b0, LAT);
        issue(1'b0, 2'b10, 32'hFF, 32'h0, 32'h000000A5, 1'b0, LAT);

        // Busy: req_valid held with changing address; one accept, ready low until response
        wait_ready();
        a0 = acc_cnt;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h10;
        @(posedge clk);
        #1;
        sb.push_back('{d: 32'hDEADBEEF, e: 1'b0, c: cyc + LAT});
        req_addr = 32'h20;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("busy_ready", {31'b0, req_ready}, 32'd0);
            req_addr = req_addr + 32'h4;
        end while (!rsp_valid && n < 20);
        req_valid = 1'b0;
        @(negedge clk);
        chk("busy_accepts", acc_cnt - a0, 32'd1);
        chk("busy_ready_back", {31'b0, req_ready}, 32'd1);

        // Reset before commit discards the write
        issue(1'b1, 2'b00, 32'h30, 32'h12345678, 32'h0, 1'b0, LAT);
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h30;
        req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        repeat (4) @(negedge clk);
        issue(1'b0, 2'b00, 32'h30, 32'h0, 32'h12345678, 1'b0, LAT);

        // LATENCY=1 instance timing
        issue1(1'b1, 32'h04, 32'h0BADC0DE, 32'h0);
        issue1(1'b0, 32'h04, 32'h0, 32'h0BADC0DE);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
